// File: rtl/blocpu_pkg.sv
// Shared constants and FSM encoding for the blocpu program loader.
// Defaults match the 8-bit blocpu core with 12-bit instructions.
package blocpu_pkg;

  localparam int DEF_CPU_WIDTH = 8;
  localparam int DEF_INSTRUCTION_WIDTH = 12;
  localparam logic [7:0] DEF_HEADER = 8'hB1;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CNT_HI  = 4'd1,
    S_CNT_LO  = 4'd2,
    S_INST_HI = 4'd3,
    S_INST_LO = 4'd4,
    S_SETUP   = 4'd5,
    S_STROBE  = 4'd6,
    S_CHECK   = 4'd7,
    S_START   = 4'd8,
    S_DONE    = 4'd9,
    S_ERROR   = 4'd10
  } state_t;

endpackage

// File: rtl/blocpu_program_loader.sv
// Byte-stream program loader: parses a framed image, writes it into
// the core instruction memory, verifies an XOR checksum, starts the core.
module blocpu_program_loader
  import blocpu_pkg::*;
#(
  parameter int CPU_WIDTH = DEF_CPU_WIDTH,
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
  parameter logic [7:0] HEADER = DEF_HEADER
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [7:0]                   in_byte,
  input  logic                         in_byte_valid,
  output logic                         out_byte_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [2*CPU_WIDTH-1:0]       out_instruction_address,
  output logic                         out_instruction_write,
  output logic                         out_core_reset,
  output logic                         out_core_run,
  output logic                         out_busy,
  output logic                         out_done,
  output logic                         out_error,
  output logic [1:0]                   out_error_code
);

  localparam int AW = 2 * CPU_WIDTH;

  state_t state_q, state_d;

  logic [15:0]                  count_q;
  logic [AW-1:0]                addr_q;
  logic [INSTRUCTION_WIDTH-1:0] inst_q;
  logic [3:0]                   hi_q;
  logic [7:0]                   csum_q;
  logic [1:0]                   code_q;
  logic                         core_reset_q;

  logic take;
  logic is_header;
  logic idle_like;

  assign take = in_byte_valid && out_byte_ready;
  assign is_header = (in_byte == HEADER);
  assign idle_like = (state_q == S_IDLE)
                  || (state_q == S_DONE)
                  || (state_q == S_ERROR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (take && is_header) state_d = S_CNT_HI;
      end
      S_CNT_HI: begin
        if (take) state_d = S_CNT_LO;
      end
      S_CNT_LO: begin
        if (take) begin
          if ({count_q[15:8], in_byte} == 16'd0)
            state_d = S_CHECK;
          else
            state_d = S_INST_HI;
        end
      end
      S_INST_HI: begin
        if (take) begin
          if (in_byte[7:4] != 4'd0)
            state_d = S_ERROR;
          else
            state_d = S_INST_LO;
        end
      end
      S_INST_LO: begin
        if (take) state_d = S_SETUP;
      end
      S_SETUP: state_d = S_STROBE;
      S_STROBE: begin
        if (count_q == 16'd1)
          state_d = S_CHECK;
        else
          state_d = S_INST_HI;
      end
      S_CHECK: begin
        if (take) begin
          if (in_byte == csum_q)
            state_d = S_START;
          else
            state_d = S_ERROR;
        end
      end
      S_START: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      addr_q       <= '0;
      inst_q       <= '0;
      hi_q         <= '0;
      csum_q       <= '0;
      code_q       <= ERR_NONE;
      core_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_reset_q <= 1'b0;
      if (idle_like && take && is_header) begin
        csum_q       <= '0;
        code_q       <= ERR_NONE;
        addr_q       <= '0;
        core_reset_q <= 1'b1;
      end
      if (state_q == S_CNT_HI && take) begin
        count_q[15:8] <= in_byte;
        csum_q        <= csum_q ^ in_byte;
      end
      if (state_q == S_CNT_LO && take) begin
        count_q[7:0] <= in_byte;
        csum_q       <= csum_q ^ in_byte;
      end
      if (state_q == S_INST_HI && take) begin
        hi_q   <= in_byte[3:0];
        csum_q <= csum_q ^ in_byte;
        if (in_byte[7:4] != 4'd0) code_q <= ERR_OPCODE;
      end
      if (state_q == S_INST_LO && take) begin
        inst_q <= INSTRUCTION_WIDTH'({hi_q, in_byte});
        csum_q <= csum_q ^ in_byte;
      end
      // Address and count advance only once the strobe has completed.
      if (state_q == S_STROBE) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q - 16'd1;
      end
      if (state_q == S_CHECK && take) begin
        if (in_byte != csum_q) code_q <= ERR_CHECKSUM;
      end
    end
  end

  assign out_byte_ready = !((state_q == S_SETUP)
                         || (state_q == S_STROBE)
                         || (state_q == S_START));
  assign out_busy = !idle_like;
  assign out_done = (state_q == S_DONE);
  assign out_error = (state_q == S_ERROR);
  assign out_error_code = code_q;
  assign out_core_run = (state_q == S_START);
  assign out_core_reset = core_reset_q;
  assign out_instruction_write = (state_q == S_STROBE);
  assign out_instruction = inst_q;
  assign out_instruction_address = addr_q;

endmodule
